param_mod_counter: RTL and testbench

- Parametrised successor to the team's 8-bit cascaded load/enable counter.
- One WIDTH-bit synchronous counter with programmable modulus and up/down direction.
- Cascade chain via ci/co, plus a registered wrap pulse.
- Used as a general-purpose event/divider counter; instances chain through ci/co to build wider counters.

---
 rtl/param_mod_counter.sv | 85 ++++++++
 tb/tb_param_mod_counter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/param_mod_counter.sv
// Parametrised modulus counter: up/down, parallel load with clamp, ci/co cascade, registered wrap pulse.
// Define PARAM_MOD_COUNTER_SAT_EN for saturating mode (the count holds at the terminal value and wrap never fires).
module param_mod_counter #(
  parameter int     WIDTH   = 8,
  parameter longint MODULUS = 256
) (
  input  logic             clk,
  input  logic             mr,
  input  logic             load,
  input  logic             en,
  input  logic             ci,
  input  logic             up,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             co,
  output logic             wrap
);

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $fatal(1, "param_mod_counter: WIDTH=%0d outside 2..32", WIDTH);
    end
    if (MODULUS < 2 || MODULUS > (64'sd1 <<< WIDTH)) begin : g_bad_mod
      $fatal(1, "param_mod_counter: MODULUS=%0d outside 2..2^WIDTH", MODULUS);
    end
  endgenerate

  // The terminal value is held one bit wider so that MODULUS = 2^WIDTH compares exactly.
  localparam logic [WIDTH:0]   LAST   = (WIDTH+1)'(MODULUS - 64'sd1);
  localparam logic [WIDTH-1:0] LAST_Q = LAST[WIDTH-1:0];

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;

  logic             w_at_last;
  logic             w_at_zero;
  logic             w_tc;
  logic             w_step;
  logic [WIDTH-1:0] w_d_clamp;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_wrap_nxt;

  assign w_at_last = ({1'b0, r_q} == LAST);
  assign w_at_zero = (r_q == '0);
  assign w_tc      = up ? w_at_last : w_at_zero;
  assign w_step    = en & ci;
  assign w_d_clamp = ({1'b0, d} > LAST) ? LAST_Q : d;

  always_comb begin
    w_q_nxt    = r_q;
    w_wrap_nxt = 1'b0;
    if (!load) begin
      w_q_nxt = w_d_clamp;
    end else if (w_step) begin
      if (w_tc) begin
`ifdef PARAM_MOD_COUNTER_SAT_EN
        w_q_nxt = r_q;
`else
        w_q_nxt    = up ? '0 : LAST_Q;
        w_wrap_nxt = 1'b1;
`endif
      end else begin
        w_q_nxt = up ? r_q + WIDTH'(1) : r_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign q    = r_q;
  assign wrap = r_wrap;
  assign tc   = w_tc;
  // co stays combinational so a chain of stages advances on the same edge.
  assign co   = w_tc & w_step;

endmodule

// File: tb/tb_param_mod_counter.sv
module tb_param_mod_counter;

`ifdef PARAM_MOD_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  int n_asrt = 0;
  int n_fail = 0;

  logic clk = 1'b0;
  logic mr  = 1'b1;
  always #5 clk = ~clk;

  logic       a_load = 1'b1, a_en = 1'b0, a_ci = 1'b1, a_up = 1'b1;
  logic [7:0] a_d = '0, a_q;
  logic       a_tc, a_co, a_wrap;
  logic       b_load = 1'b1, b_en = 1'b0, b_ci = 1'b1, b_up = 1'b1;
  logic [3:0] b_d = '0, b_q;
  logic       b_tc, b_co, b_wrap;
  logic       c_load = 1'b1, c_en = 1'b0, c_up = 1'b1;
  logic [3:0] lo_d = '0, hi_d = '0, lo_q, hi_q;
  logic       lo_tc, lo_co, lo_wrap, hi_tc, hi_co, hi_wrap;

  param_mod_counter #(.WIDTH(8), .MODULUS(256)) u_a (
    .clk(clk), .mr(mr), .load(a_load), .en(a_en), .ci(a_ci), .up(a_up), .d(a_d),
    .q(a_q), .tc(a_tc), .co(a_co), .wrap(a_wrap));

  param_mod_counter #(.WIDTH(4), .MODULUS(10)) u_b (
    .clk(clk), .mr(mr), .load(b_load), .en(b_en), .ci(b_ci), .up(b_up), .d(b_d),
    .q(b_q), .tc(b_tc), .co(b_co), .wrap(b_wrap));

  param_mod_counter #(.WIDTH(4), .MODULUS(16)) u_lo (
    .clk(clk), .mr(mr), .load(c_load), .en(c_en), .ci(1'b1), .up(c_up), .d(lo_d),
    .q(lo_q), .tc(lo_tc), .co(lo_co), .wrap(lo_wrap));

  param_mod_counter #(.WIDTH(4), .MODULUS(16)) u_hi (
    .clk(clk), .mr(mr), .load(c_load), .en(c_en), .ci(lo_co), .up(c_up), .d(hi_d),
    .q(hi_q), .tc(hi_tc), .co(hi_co), .wrap(hi_wrap));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    n_fail++;
    $error("FAIL timeout: test did not finish within the wait limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

  initial begin
    tick();
    chk("rst_a_q", a_q, 8'h00);
    chk("rst_a_wrap", a_wrap, 1'b0);
    chk("rst_b_q", b_q, 4'h0);
    chk("rst_c_q", {hi_q, lo_q}, 8'h00);
    mr = 1'b0;

    a_en = 1'b1; a_load = 1'b0; a_d = 8'h35;
    tick();
    a_load = 1'b1;
    tick();
    tick();
    chk("cnt_a_q", a_q, 8'h37);
    #1 mr = 1'b1;
    #1;
    chk("async_rst_q", a_q, 8'h00);
    chk("async_rst_wrap", a_wrap, 1'b0);
    #1 mr = 1'b0;
    tick();
    chk("resume_q1", a_q, 8'h01);
    tick();
    chk("resume_q2", a_q, 8'h02);

    a_load = 1'b0; a_d = 8'hFE;
    tick();
    chk("load_fe", a_q, 8'hFE);
    a_load = 1'b1;
    tick();
    chk("up_ff_q", a_q, 8'hFF);
    chk("up_ff_tc", a_tc, 1'b1);
    chk("up_ff_co", a_co, 1'b1);
    chk("up_ff_wrap", a_wrap, 1'b0);
    a_up = 1'b0;
    #1;
    chk("dir_tc_down_at_ff", a_tc, 1'b0);
    a_up = 1'b1; a_en = 1'b0;
    #1;
    chk("tc_no_en", a_tc, 1'b1);
    chk("co_no_en", a_co, 1'b0);
    a_en = 1'b1;
    tick();
    chk("wrap_q", a_q, SAT ? 8'hFF : 8'h00);
    chk("wrap_pulse", a_wrap, !SAT);
    tick();
    chk("after_wrap_q", a_q, SAT ? 8'hFF : 8'h01);
    chk("after_wrap_pulse", a_wrap, 1'b0);

    b_en = 1'b1; b_up = 1'b0; b_load = 1'b0; b_d = 4'd1;
    tick();
    chk("b_load1", b_q, 4'd1);
    chk("b_tc_at1", b_tc, 1'b0);
    b_load = 1'b1;
    tick();
    chk("b_dn_q0", b_q, 4'd0);
    chk("b_dn_tc0", b_tc, 1'b1);
    chk("b_dn_co0", b_co, 1'b1);
    tick();
    chk("b_dn_wrap_q", b_q, SAT ? 4'd0 : 4'd9);
    chk("b_dn_wrap_pulse", b_wrap, !SAT);
    tick();
    chk("b_dn_after_q", b_q, SAT ? 4'd0 : 4'd8);
    chk("b_dn_after_wrap", b_wrap, 1'b0);
    b_load = 1'b0; b_d = 4'd12;
    tick();
    chk("b_clamp", b_q, 4'd9);

    b_up = 1'b1; b_d = 4'd3;
    #1;
    chk("b_tc_up9", b_tc, 1'b1);
    tick();
    chk("b_prio_q", b_q, 4'd3);
    chk("b_prio_wrap", b_wrap, 1'b0);

    b_load = 1'b1; b_ci = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("b_hold_q", b_q, 4'd3);
      chk("b_hold_co", b_co, 1'b0);
    end
    b_ci = 1'b1;
    tick();
    chk("b_hold_release", b_q, 4'd4);

    c_en = 1'b1; c_up = 1'b1; c_load = 1'b0; lo_d = 4'hF; hi_d = 4'h0;
    tick();
    chk("c_load", {hi_q, lo_q}, 8'h0F);
    chk("c_lo_co", lo_co, 1'b1);
    c_load = 1'b1;
    tick();
    chk("c_up", {hi_q, lo_q}, SAT ? 8'h1F : 8'h10);
    chk("c_lo_wrap", lo_wrap, !SAT);
    c_up = 1'b0;
    tick();
    chk("c_down", {hi_q, lo_q}, SAT ? 8'h1E : 8'h0F);

    b_up = 1'b1; b_load = 1'b0; b_d = 4'd8;
    tick();
    b_load = 1'b1;
    tick();
    chk("sat_up_9", b_q, 4'd9);
    tick();
    chk("sat_up_hold1", b_q, SAT ? 4'd9 : 4'd0);
    chk("sat_up_wrap1", b_wrap, !SAT);
    tick();
    chk("sat_up_hold2", b_q, SAT ? 4'd9 : 4'd1);
    chk("sat_up_wrap2", b_wrap, 1'b0);
    b_up = 1'b0; b_load = 1'b0; b_d = 4'd1;
    tick();
    b_load = 1'b1;
    tick();
    chk("sat_dn_0", b_q, 4'd0);
    tick();
    chk("sat_dn_hold", b_q, SAT ? 4'd0 : 4'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
